// File: rtl/dcache_bridge_responder.sv
// ---------------------------------------------------------------------------
// dcache_bridge_responder
//
// Bridge-side responder for the D$ line-transfer interface. It takes one line
// request at a time (fill or dirty writeback), moves the line as BEATS
// single-word transactions over a word-wide memory port with only one beat
// outstanding, and answers the D$ with a single response: the assembled line
// for a fill, or a completion (all-zero data) for a writeback.
//
// Optional feature: define DCACHE_BRIDGE_TIMEOUT_EN to add a per-beat
// watchdog. A beat that spends TIMEOUT_CYCLES cycles in ISSUE/WAIT aborts the
// transfer and the response carries resp_err_o=1 and zero data. Without the
// macro resp_err_o is tied low and the bridge waits indefinitely.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_*                   D$ request (valid/ready, write flag, line address,
//                           writeback line data)
//   resp_*                  D$ response (valid/ready, line data, timeout error)
//   mem_req_*, mem_we_o,
//   mem_addr_o, mem_wdata_o memory beat request (valid/ready, write, address,
//                           write data)
//   mem_resp_valid_i,
//   mem_rdata_i             memory beat answer (read data or write ack)
// ---------------------------------------------------------------------------
module dcache_bridge_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_BYTES     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [LINE_BYTES*8-1:0] req_data_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [LINE_BYTES*8-1:0] resp_data_o,
  output logic                    resp_err_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int BEATS      = LINE_W / DATA_WIDTH;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  state_e                  state_r;
  logic [BEAT_W-1:0]       beat_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic                    write_r;
  logic [LINE_W-1:0]       buf_r;

  logic [ADDR_WIDTH-1:0]   req_base_s;
  logic                    last_beat_s;
  logic [BEAT_W-1:0]       beat_next_s;
  logic [LINE_W-1:0]       buf_fill_s;

  // Byte address of a beat; the base is line aligned so the add never leaves the line.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [BEAT_W-1:0]     beat);
    return base + ADDR_WIDTH'(beat) * ADDR_WIDTH'(WORD_BYTES);
  endfunction

  // Word of a line buffer selected by beat index.
  function automatic logic [DATA_WIDTH-1:0] beat_word(input logic [LINE_W-1:0] line,
                                                      input logic [BEAT_W-1:0] beat);
    return line[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Aligned request base, beat bookkeeping and the buffer with the current read word merged in.
  always_comb begin
    req_base_s  = req_addr_i & ~ADDR_WIDTH'(LINE_BYTES - 1);
    last_beat_s = (beat_r == BEAT_W'(BEATS - 1));
    beat_next_s = beat_r + BEAT_W'(1);
    buf_fill_s  = buf_r;
    if (!write_r) begin
      buf_fill_s[int'(beat_r)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i;
    end else begin
      buf_fill_s = buf_r;
    end
  end

`ifdef DCACHE_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_r;
  logic            to_hit_s;

  // Watchdog fires on the TIMEOUT_CYCLES-th cycle a beat spends in ISSUE/WAIT.
  always_comb begin
    to_hit_s = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
  end
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
  assign resp_err_o       = 1'b0;
`endif

  // Transfer FSM; every port output is a register updated on the transition that sets it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r         <= ST_IDLE;
      beat_r          <= '0;
      base_r          <= '0;
      write_r         <= 1'b0;
      buf_r           <= '0;
      req_ready_o     <= 1'b1;
      resp_valid_o    <= 1'b0;
      resp_data_o     <= '0;
      mem_req_valid_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
`ifdef DCACHE_BRIDGE_TIMEOUT_EN
      to_cnt_r        <= '0;
      resp_err_o      <= 1'b0;
`endif
    end else begin
`ifdef DCACHE_BRIDGE_TIMEOUT_EN
      // Runs through ISSUE and WAIT; every entry into ISSUE below restarts it.
      if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
`endif
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            base_r          <= req_base_s;
            write_r         <= req_write_i;
            beat_r          <= '0;
            state_r         <= ST_ISSUE;
            req_ready_o     <= 1'b0;
            mem_req_valid_o <= 1'b1;
            mem_we_o        <= req_write_i;
            mem_addr_o      <= req_base_s;
`ifdef DCACHE_BRIDGE_TIMEOUT_EN
            to_cnt_r        <= '0;
`endif
            if (req_write_i) begin
              buf_r       <= req_data_i;
              mem_wdata_o <= req_data_i[DATA_WIDTH-1:0];
            end else begin
              mem_wdata_o <= beat_word(buf_r, BEAT_W'(0));
            end
          end
        end
        ST_ISSUE: begin
`ifdef DCACHE_BRIDGE_TIMEOUT_EN
          if (to_hit_s) begin
            state_r         <= ST_RESPOND;
            mem_req_valid_o <= 1'b0;
            resp_valid_o    <= 1'b1;
            resp_err_o      <= 1'b1;
            resp_data_o     <= '0;
          end else
`endif
          if (mem_req_ready_i) begin
            state_r         <= ST_WAIT;
            mem_req_valid_o <= 1'b0;
          end
        end
        ST_WAIT: begin
`ifdef DCACHE_BRIDGE_TIMEOUT_EN
          if (to_hit_s) begin
            state_r      <= ST_RESPOND;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_data_o  <= '0;
          end else
`endif
          if (mem_resp_valid_i) begin
            buf_r <= buf_fill_s;
            if (last_beat_s) begin
              state_r      <= ST_RESPOND;
              resp_valid_o <= 1'b1;
              resp_data_o  <= write_r ? '0 : buf_fill_s;
            end else begin
              beat_r          <= beat_next_s;
              state_r         <= ST_ISSUE;
              mem_req_valid_o <= 1'b1;
              mem_addr_o      <= beat_addr(base_r, beat_next_s);
              mem_wdata_o     <= beat_word(buf_fill_s, beat_next_s);
`ifdef DCACHE_BRIDGE_TIMEOUT_EN
              to_cnt_r        <= '0;
`endif
            end
          end
        end
        ST_RESPOND: begin
          if (resp_ready_i) begin
            state_r      <= ST_IDLE;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            req_ready_o  <= 1'b1;
`ifdef DCACHE_BRIDGE_TIMEOUT_EN
            resp_err_o   <= 1'b0;
`endif
          end
        end
        default: begin
          state_r         <= ST_IDLE;
          req_ready_o     <= 1'b1;
          resp_valid_o    <= 1'b0;
          mem_req_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dcache_bridge_responder.md
Name: dcache_bridge_responder

Overview:
- Bridge-side responder for the D$ line-transfer request/response interface.
- Accepts one line request at a time from the D$: either a line fill (read) or a dirty-line writeback (write).
- Each line is carried out as BEATS single-word transactions on a simple word-wide memory port.
- Answers the D$ with one response: the full assembled line for a fill, or a completion for a writeback.

Parameters:
- DATA_WIDTH, 32: memory-port word width in bits.
- ADDR_WIDTH, 32: address width in bits.
- LINE_BYTES, 64: cache line size in bytes. BEATS = LINE_BYTES*8/DATA_WIDTH (16 at defaults).
- TIMEOUT_CYCLES, 1024: watchdog limit per beat. Used only with DCACHE_BRIDGE_TIMEOUT_EN.

Ports:
- clk_i, in, 1: single clock. All logic is on the rising edge.
- rst_i, in, 1: synchronous, active-high reset.
- req_valid_i, in, 1: D$ request valid.
- req_ready_o, out, 1: responder can accept a request.
- req_write_i, in, 1: 1 = writeback, 0 = fill.
- req_addr_i, in, ADDR_WIDTH: line address. Low $clog2(LINE_BYTES) bits are ignored and treated as zero.
- req_data_i, in, LINE_BYTES*8: writeback line data. Ignored for fills.
- resp_valid_o, out, 1: response valid.
- resp_ready_i, in, 1: D$ accepts the response.
- resp_data_o, out, LINE_BYTES*8: filled line. All zero for writebacks.
- resp_err_o, out, 1: transfer aborted by timeout. Qualified by resp_valid_o.
- mem_req_valid_o, out, 1: memory beat request valid.
- mem_req_ready_i, in, 1: memory accepts the beat.
- mem_we_o, out, 1: beat is a write.
- mem_addr_o, out, ADDR_WIDTH: beat byte address.
- mem_wdata_o, out, DATA_WIDTH: beat write data.
- mem_resp_valid_i, in, 1: read data valid, or write acknowledge.
- mem_rdata_i, in, DATA_WIDTH: beat read data.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State goes to IDLE; the beat counter clears; the line buffer clears to 0.
  - req_ready_o=1. resp_valid_o, resp_err_o and mem_req_valid_o are 0.
  - mem_we_o, mem_addr_o, mem_wdata_o and resp_data_o are 0.
  - Reset mid-transfer abandons the transfer: no response is issued and the partial line is discarded.
- State machine: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o: latch the line base address (offset bits zeroed) and req_write_i. For a write, also latch req_data_i into the line buffer.
  - Then beat=0 and go to ISSUE.
- ISSUE:
  - mem_req_valid_o=1, mem_we_o=latched write flag.
  - mem_addr_o = base + beat*(DATA_WIDTH/8).
  - mem_wdata_o = buffer[beat*DATA_WIDTH +: DATA_WIDTH].
  - All memory outputs hold stable until mem_req_ready_i; on the handshake go to WAIT.
- WAIT:
  - mem_req_valid_o=0.
  - On mem_resp_valid_i: for a read, buffer[beat] <= mem_rdata_i. Writes ignore mem_rdata_i.
  - If beat==BEATS-1, go to RESPOND; otherwise beat++ and go to ISSUE.
- Only one beat is outstanding at a time. mem_resp_valid_i outside WAIT is ignored.
- RESPOND:
  - resp_valid_o=1.
  - resp_data_o = buffer for a read, 0 for a write.
  - Data holds stable until resp_ready_i. On the handshake go to IDLE and drop resp_valid_o the next cycle.
- req_ready_o is 1 only in IDLE. Requests arriving in any other state are not accepted and not lost; the D$ keeps req_valid_i high.
- Minimum latency, memory ready and responding with zero wait:
  - Request handshake at cycle 0.
  - Beat k issued at cycle 1+2k; its response at cycle 2+2k.
  - resp_valid_o at cycle 2*BEATS+1 (cycle 33 at defaults).
- Back-to-back requests: a new request is accepted the cycle after the RESPOND handshake.
- The beat counter is $clog2(BEATS) bits wide and never wraps past BEATS-1 within a transfer.
- Address add is modulo 2^ADDR_WIDTH; it never crosses the line because the base is aligned.

Optional Feature:
- Macro: DCACHE_BRIDGE_TIMEOUT_EN.
- With the macro:
  - A per-beat counter runs in ISSUE and WAIT and clears on entering each ISSUE.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: mem_req_valid_o drops and the FSM goes to RESPOND.
  - resp_err_o=1 and resp_data_o=0 for that response.
  - Later mem_resp_valid_i is ignored until the next WAIT.
- Without the macro: no counter exists, resp_err_o is tied to 0, and the FSM waits indefinitely.

Test Plan:
- Fill:
  - Stimulus: req_addr_i=0x0000_1234 (write=0); memory returns word k = 0xA000_0000+k with zero wait.
  - Response: mem_addr_o steps 0x1200, 0x1204, …, 0x123C. resp_data_o word k = 0xA000_0000+k. resp_valid_o rises at cycle 33.
- Writeback:
  - Stimulus: req_addr_i=0x8000_0040 (write=1); line word k = k*0x11111111.
  - Response: 16 beats with mem_we_o=1, mem_addr_o 0x8000_0040..0x8000_007C and matching mem_wdata_o. Then a response with resp_data_o=0 and resp_err_o=0.
- Backpressure:
  - Stimulus: mem_req_ready_i low 3 cycles per beat; resp_ready_i low 5 cycles.
  - Response: memory outputs are stable while stalled; resp_data_o is stable and resp_valid_o is held.
  - A second req_valid_i during the transfer sees req_ready_o=0 and is accepted the cycle after the response handshake.
- Reset:
  - Stimulus: assert rst_i during beat 7 of a fill.
  - Response: next cycle state is IDLE, req_ready_o=1, resp_valid_o=0, and no response ever issues. A subsequent fill returns a correct, fully new line.
- Stray response: mem_resp_valid_i pulsed in IDLE and in ISSUE -> line buffer and beat count are unchanged.
- Timeout (macro on, TIMEOUT_CYCLES=8):
  - Stimulus: memory never responds to beat 0.
  - Response: resp_valid_o=1 with resp_err_o=1 and resp_data_o=0. A subsequent normal fill completes with resp_err_o=0.
